wh_flit_packetizer: RTL and testbench

//  Local-port network interface: sits directly upstream of a mesh router's local input.

---
 rtl/wh_noc_pkg.sv | 36 +++
 rtl/wh_req_fifo.sv | 58 +++++
 rtl/wh_flit_packetizer.sv | 133 +++++++++++++
 tb/tb_wh_flit_packetizer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wh_noc_pkg.sv
// Shared wormhole NoC definitions: flit type codes, flit type and flit builders.
package wh_noc_pkg;

    localparam int unsigned FLIT_W         = 8;
    localparam int unsigned BODIES_PER_PKT = 5;

    localparam logic [1:0] FLIT_HEAD = 2'b00;
    localparam logic [1:0] FLIT_BODY = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {StIdle, StHead, StBody, StTail} pkt_state_e;

    function automatic flit_t make_head(input logic [2:0] dest_x, input logic [2:0] dest_y);
        return {dest_x, dest_y, FLIT_HEAD};
    endfunction

    // Body k carries the k-th 6-bit slice of the payload, MSB first.
    function automatic flit_t make_body(input logic [31:0] data, input logic [2:0] idx);
        logic [5:0] slice;
        case (idx)
            3'd0:    slice = data[31:26];
            3'd1:    slice = data[25:20];
            3'd2:    slice = data[19:14];
            3'd3:    slice = data[13:8];
            default: slice = data[7:2];
        endcase
        return {slice, FLIT_BODY};
    endfunction

    function automatic flit_t make_tail(input logic [31:0] data);
        return {data[1:0], 4'b0000, FLIT_TAIL};
    endfunction

endpackage

// File: rtl/wh_req_fifo.sv
// Synchronous request FIFO with count-based full/empty; push while full is legal only with pop.
module wh_req_fifo #(
    parameter int unsigned WIDTH = 38,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wh_flit_packetizer.sv
// Local-port network interface: serialises (dest, 32-bit word) requests into
// 7-flit wormhole packets for the router's local input, honouring router_full.
module wh_flit_packetizer
    import wh_noc_pkg::*;
#(
    parameter int unsigned LINK_WIDTHS  = 8,
    parameter int unsigned COORD_W      = 3,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned REQ_DEPTH    = 4,
    parameter int unsigned MESH_COLUMNS = 4,
    parameter int unsigned MESH_ROWS    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [COORD_W-1:0]     req_dest_x,
    input  logic [COORD_W-1:0]     req_dest_y,
    input  logic [DATA_W-1:0]      req_data,
    output logic                   req_drop,
    input  logic                   router_full,
    output logic [LINK_WIDTHS-1:0] flit_out,
    output logic                   flit_wr_en,
    output logic                   pkt_sent,
    output logic                   busy
);

    localparam int unsigned ENTRY_W = 2 * COORD_W + DATA_W;

    logic               in_range;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;

    pkt_state_e         state;
    logic [2:0]         body_idx;
    logic [COORD_W-1:0] pkt_x;
    logic [COORD_W-1:0] pkt_y;
    logic [DATA_W-1:0]  pkt_data;
    flit_t              cur_flit;

    assign in_range  = (32'(req_dest_x) < MESH_COLUMNS) && (32'(req_dest_y) < MESH_ROWS);
    assign req_ready = !fifo_full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && in_range;

    assign flit_wr_en = (state != StIdle) && !router_full && !rst;
    assign pkt_sent   = (state == StTail) && flit_wr_en;
    assign busy       = (state != StIdle) || !fifo_empty;

    // Reload straight from the FIFO on the tail write so back-to-back packets have no bubble.
    assign pop = !rst && !fifo_empty && ((state == StIdle) || ((state == StTail) && flit_wr_en));

    wh_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({req_dest_x, req_dest_y, req_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            req_drop <= 1'b0;
        end else begin
            req_drop <= accept && !in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            body_idx <= '0;
            pkt_x    <= '0;
            pkt_y    <= '0;
            pkt_data <= '0;
        end else begin
            if (pop) begin
                {pkt_x, pkt_y, pkt_data} <= fifo_rdata;
            end
            case (state)
                StIdle: begin
                    if (pop) begin
                        state <= StHead;
                    end
                end
                StHead: begin
                    if (flit_wr_en) begin
                        state    <= StBody;
                        body_idx <= '0;
                    end
                end
                StBody: begin
                    if (flit_wr_en) begin
                        if (body_idx == 3'(BODIES_PER_PKT - 1)) begin
                            state <= StTail;
                        end else begin
                            body_idx <= body_idx + 3'd1;
                        end
                    end
                end
                StTail: begin
                    if (flit_wr_en) begin
                        state <= pop ? StHead : StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        cur_flit = '0;
        unique case (state)
            StIdle: cur_flit = '0;
            StHead: cur_flit = make_head(pkt_x, pkt_y);
            StBody: cur_flit = make_body(pkt_data, body_idx);
            StTail: cur_flit = make_tail(pkt_data);
        endcase
    end

    assign flit_out = LINK_WIDTHS'(cur_flit);

endmodule

// File: tb/tb_wh_flit_packetizer.sv
// Directed self-checking bench for wh_flit_packetizer.
module tb_wh_flit_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_dest_x = '0;
    logic [2:0]  req_dest_y = '0;
    logic [31:0] req_data = '0;
    logic        req_drop;
    logic        router_full = 1'b0;
    logic [7:0]  flit_out;
    logic        flit_wr_en;
    logic        pkt_sent;
    logic        busy;

    wh_flit_packetizer dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dest_x  (req_dest_x),
        .req_dest_y  (req_dest_y),
        .req_data    (req_data),
        .req_drop    (req_drop),
        .router_full (router_full),
        .flit_out    (flit_out),
        .flit_wr_en  (flit_wr_en),
        .pkt_sent    (pkt_sent),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         npkt    = 0;
    logic [7:0] flits[$];
    int         wr_cyc[$];
    logic [7:0] sent_flit[$];
    logic [7:0] exp1 [7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (flit_wr_en) begin
            flits.push_back(flit_out);
            wr_cyc.push_back(cyc);
        end
        if (pkt_sent) begin
            npkt = npkt + 1;
            sent_flit.push_back(flit_out);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] x, input logic [2:0] y, input logic [31:0] d);
        req_valid  = 1'b1;
        req_dest_x = x;
        req_dest_y = y;
        req_data   = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_flits(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (flits.size() >= target) break;
            @(negedge clk);
            #1;
        end
        check_eq(tag, 64'(flits.size() >= target), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base2;
        int pbase;
        int acc;

        exp1[0] = 8'h6C; exp1[1] = 8'hDD; exp1[2] = 8'hA9; exp1[3] = 8'hD9;
        exp1[4] = 8'hF9; exp1[5] = 8'hED; exp1[6] = 8'hC2;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst req_ready", req_ready, 1);
        check_eq("rst req_drop", req_drop, 0);
        check_eq("rst flit_wr_en", flit_wr_en, 0);
        check_eq("rst flit_out", flit_out, 0);
        check_eq("rst pkt_sent", pkt_sent, 0);
        check_eq("rst busy", busy, 0);
        @(posedge clk);
        #1;

        // 1: single packet, no backpressure
        base  = flits.size();
        pbase = npkt;
        send(3'd3, 3'd3, 32'hDEADBEEF);
        @(negedge clk);
        check_eq("t1 pop gap busy", busy, 1);
        check_eq("t1 pop gap wr_en", flit_wr_en, 0);
        @(negedge clk);
        check_eq("t1 head wr_en", flit_wr_en, 1);
        check_eq("t1 head flit", flit_out, 8'h6C);
        #1;
        wait_flits(base + 7, 20, "t1 flit timeout");
        for (int k = 0; k < 7; k++) check_eq($sformatf("t1 flit%0d", k), flits[base+k], exp1[k]);
        check_eq("t1 contiguous", wr_cyc[base+6] - wr_cyc[base], 6);
        check_eq("t1 pkt_sent count", npkt - pbase, 1);
        check_eq("t1 pkt_sent on tail", sent_flit[$], 8'hC2);
        @(posedge clk);
        #1;

        // 2: router_full for 3 cycles while A9 is presented
        base = flits.size();
        send(3'd3, 3'd3, 32'hDEADBEEF);
        wait_flits(base + 2, 10, "t2 reach body1 timeout");
        @(posedge clk);
        #1;
        router_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("t2 stall wr_en", flit_wr_en, 0);
            check_eq("t2 stall flit held", flit_out, 8'hA9);
            @(posedge clk);
            #1;
        end
        router_full = 1'b0;
        wait_flits(base + 7, 20, "t2 flit timeout");
        for (int k = 0; k < 7; k++) check_eq($sformatf("t2 flit%0d", k), flits[base+k], exp1[k]);
        check_eq("t2 span", wr_cyc[base+6] - wr_cyc[base], 9);
        @(posedge clk);
        #1;

        // 3: two back-to-back requests; head {x=1,y=2,00}=28, {x=3,y=0,00}=60
        base  = flits.size();
        pbase = npkt;
        send(3'd1, 3'd2, 32'h0000_0000);
        send(3'd3, 3'd0, 32'hFFFF_FFFF);
        wait_flits(base + 14, 40, "t3 flit timeout");
        check_eq("t3 head1", flits[base], 8'h28);
        check_eq("t3 body1_0", flits[base+1], 8'h01);
        check_eq("t3 tail1", flits[base+6], 8'h02);
        check_eq("t3 head2", flits[base+7], 8'h60);
        check_eq("t3 body2_0", flits[base+8], 8'hFD);
        check_eq("t3 tail2", flits[base+13], 8'hC2);
        check_eq("t3 contiguous", wr_cyc[base+13] - wr_cyc[base], 13);
        check_eq("t3 pkt_sent count", npkt - pbase, 2);
        @(posedge clk);
        #1;

        // 4: router_full throughout, req_valid held -> FIFO plus packet register fill
        base        = flits.size();
        pbase       = npkt;
        acc         = 0;
        router_full = 1'b1;
        req_valid   = 1'b1;
        req_dest_x  = 3'd2;
        req_dest_y  = 3'd1;
        req_data    = 32'hA5A5_A5A5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready) acc++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("t4 accepts", acc, 5);
        check_eq("t4 req_ready low", req_ready, 0);
        check_eq("t4 wr_en blocked", flit_wr_en, 0);
        check_eq("t4 head presented", flit_out, 8'h44);
        check_eq("t4 busy", busy, 1);
        @(posedge clk);
        #1;
        router_full = 1'b0;
        wait_flits(base + 35, 60, "t4 flit timeout");
        check_eq("t4 contiguous", wr_cyc[base+34] - wr_cyc[base], 34);
        for (int k = 0; k < 5; k++) check_eq($sformatf("t4 head%0d", k), flits[base+7*k], 8'h44);
        check_eq("t4 pkt_sent count", npkt - pbase, 5);
        @(negedge clk);
        check_eq("t4 req_ready back", req_ready, 1);
        check_eq("t4 busy clear", busy, 0);
        @(posedge clk);
        #1;

        // 5: out-of-range destinations are dropped
        base = flits.size();
        send(3'd4, 3'd0, 32'h1234_5678);
        @(negedge clk);
        check_eq("t5 drop x", req_drop, 1);
        check_eq("t5 busy x", busy, 0);
        check_eq("t5 wr_en x", flit_wr_en, 0);
        @(negedge clk);
        check_eq("t5 drop one cycle", req_drop, 0);
        @(posedge clk);
        #1;
        send(3'd0, 3'd4, 32'h1234_5678);
        @(negedge clk);
        check_eq("t5 drop y", req_drop, 1);
        repeat (3) @(negedge clk);
        check_eq("t5 no flits", flits.size() - base, 0);
        check_eq("t5 busy idle", busy, 0);
        @(posedge clk);
        #1;

        // 6: reset mid-packet, then a clean packet
        base = flits.size();
        send(3'd0, 3'd1, 32'h1234_5678);
        wait_flits(base + 3, 15, "t6 partial timeout");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6 wr_en in rst", flit_wr_en, 0);
        check_eq("t6 pkt_sent in rst", pkt_sent, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6 busy after rst", busy, 0);
        check_eq("t6 flit_out after rst", flit_out, 0);
        check_eq("t6 req_ready after rst", req_ready, 1);
        check_eq("t6 truncated worm", flits.size() - base, 3);
        @(posedge clk);
        #1;
        base2 = flits.size();
        send(3'd2, 3'd3, 32'hDEADBEEF);
        wait_flits(base2 + 7, 20, "t6 flit timeout");
        check_eq("t6 new head", flits[base2], 8'h4C);
        check_eq("t6 new body0", flits[base2+1], 8'hDD);
        check_eq("t6 new tail", flits[base2+6], 8'hC2);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
